vector_checker: RTL and testbench

VECTOR_CHECKER -- requirements
Module: vector_checker

---
 rtl/vector_checker_pkg.sv | 32 +++
 rtl/vector_checker_gate_ref.sv | 25 ++
 rtl/vector_checker.sv | 139 +++++++++++++
 tb/tb_vector_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vector_checker_pkg.sv
// Shared encodings and types for the vector checker.
package vector_checker_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FAIL_W = 3;

    // Golden gate function encodings.
    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_BAD  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One captured sample: stimulus pair and DUT response.
    typedef struct packed {
        logic a;
        logic b;
        logic out;
    } vec_t;

endpackage

// File: rtl/vector_checker_gate_ref.sv
// Combinational golden model of the selected two-input gate.
module gate_ref
    import vector_checker_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic [OP_W-1:0] op,
    output logic            expected
);

    // Evaluate the selected function; unknown encodings yield 0.
    always_comb begin
        expected = 1'b0;
        case (op)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_XOR:  expected = a ^ b;
            OP_NAND: expected = ~(a & b);
            OP_NOR:  expected = ~(a | b);
            OP_XNOR: expected = ~(a ^ b);
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/vector_checker.sv
// Checks a fixed-length run of DUT samples against a golden gate function.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int unsigned GATE_OP     = 2,
    parameter int unsigned NUM_VECTORS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_a,
    input  logic              in_b,
    input  logic              in_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [FAIL_W-1:0] first_fail,
    output logic              first_fail_valid
);

    // Reject unsupported configurations at elaboration.
    if (GATE_OP > 5) begin : g_bad_gate_op
        $error("vector_checker: GATE_OP %0d is not a supported gate", GATE_OP);
    end
    if (NUM_VECTORS < 1 || NUM_VECTORS > 255) begin : g_bad_num_vectors
        $error("vector_checker: NUM_VECTORS %0d outside 1..255", NUM_VECTORS);
    end

    localparam logic [OP_W-1:0]  OP_SEL   = (GATE_OP > 5) ? OP_BAD : OP_W'(GATE_OP);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    vec_t             first_fail_q, first_fail_d;
    logic             first_fail_valid_q, first_fail_valid_d;

    logic expected;
    logic accept;
    logic mismatch;

    gate_ref u_gate_ref (
        .a        (in_a),
        .b        (in_b),
        .op       (OP_SEL),
        .expected (expected)
    );

    // in_ready_q is a pure state decode, so accept has no in_valid->in_ready path.
    assign accept   = in_valid & in_ready_q;
    assign mismatch = in_out != expected;

    // Next-state, counter and capture logic; status flags decode the next state.
    always_comb begin
        state_d            = state_q;
        sample_count_d     = sample_count_q;
        err_count_d        = err_count_q;
        first_fail_d       = first_fail_q;
        first_fail_valid_d = first_fail_valid_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d            = ST_RUN;
                    sample_count_d     = '0;
                    err_count_d        = '0;
                    first_fail_d       = '0;
                    first_fail_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    sample_count_d = sample_count_q + 8'd1;
                    if (mismatch) begin
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        if (!first_fail_valid_q) begin
                            first_fail_d       = '{a: in_a, b: in_b, out: in_out};
                            first_fail_valid_d = 1'b1;
                        end
                    end
                    if (sample_count_d == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = state_d == ST_RUN;
        busy_d     = state_d == ST_RUN;
        done_d     = state_d == ST_DONE;
        pass_d     = (state_d == ST_DONE) && (err_count_d == '0);
    end

    // State and registered outputs; reset forces IDLE with all outputs low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            in_ready_q         <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            sample_count_q     <= '0;
            err_count_q        <= '0;
            first_fail_q       <= '0;
            first_fail_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            in_ready_q         <= in_ready_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
            sample_count_q     <= sample_count_d;
            err_count_q        <= err_count_d;
            first_fail_q       <= first_fail_d;
            first_fail_valid_q <= first_fail_valid_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign sample_count     = sample_count_q;
    assign err_count        = err_count_q;
    assign first_fail       = first_fail_q;
    assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_vector_checker.sv
// Randomised self-checking bench: two checker instances against a truth-table model.
module tb_vector_checker;

    localparam int unsigned OP0 = 2;    // XOR
    localparam int unsigned NV0 = 4;
    localparam int unsigned OP1 = 3;    // NAND
    localparam int unsigned NV1 = 255;

    logic clk = 1'b0;
    logic rst_n;
    logic start, in_valid, in_a, in_b, in_out;

    logic [1:0]      rdy, bsy, dn, ps, ffv;
    logic [1:0][7:0] cnt, err;
    logic [1:0][2:0] ff;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one entry per instance.
    int unsigned m_op   [2];
    int unsigned m_nv   [2];
    bit          m_run  [2];
    bit          m_done [2];
    int unsigned m_cnt  [2];
    int unsigned m_err  [2];
    bit [2:0]    m_ff   [2];
    bit          m_ffv  [2];

    always #5 clk = ~clk;

    vector_checker #(.GATE_OP(OP0), .NUM_VECTORS(NV0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b), .in_out(in_out),
        .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .sample_count(cnt[0]),
        .err_count(err[0]), .first_fail(ff[0]), .first_fail_valid(ffv[0])
    );

    vector_checker #(.GATE_OP(OP1), .NUM_VECTORS(NV1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b), .in_out(in_out),
        .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .sample_count(cnt[1]),
        .err_count(err[1]), .first_fail(ff[1]), .first_fail_valid(ffv[1])
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Truth table per op, indexed by {a,b}.
    function automatic bit golden(input int unsigned op, input bit a, input bit b);
        logic [3:0] tt;
        case (op)
            0:       tt = 4'b1000;
            1:       tt = 4'b1110;
            2:       tt = 4'b0110;
            3:       tt = 4'b0111;
            4:       tt = 4'b0001;
            5:       tt = 4'b1001;
            default: tt = 4'b0000;
        endcase
        return tt[{a, b}];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
            m_err[i] = 0; m_ff[i] = 0;  m_ffv[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit s, input bit v, input bit a, input bit b, input bit o);
        if (m_run[i]) begin
            if (v) begin
                m_cnt[i]++;
                if (o != golden(m_op[i], a, b)) begin
                    if (m_err[i] < 255) m_err[i]++;
                    if (!m_ffv[i]) begin
                        m_ff[i]  = {a, b, o};
                        m_ffv[i] = 1;
                    end
                end
                if (m_cnt[i] == m_nv[i]) begin
                    m_run[i]  = 0;
                    m_done[i] = 1;
                end
            end
        end else if (s) begin
            m_run[i] = 1; m_done[i] = 0; m_cnt[i] = 0;
            m_err[i] = 0; m_ff[i] = 0;  m_ffv[i] = 0;
        end
    endtask

    task automatic check_all(input int i);
        check($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(m_run[i]));
        check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_run[i]));
        check($sformatf("done%0d", i), 32'(dn[i]), 32'(m_done[i]));
        check($sformatf("pass%0d", i), 32'(ps[i]), 32'(m_done[i] && m_err[i] == 0));
        check($sformatf("sample_count%0d", i), 32'(cnt[i]), m_cnt[i]);
        check($sformatf("err_count%0d", i), 32'(err[i]), m_err[i]);
        check($sformatf("first_fail%0d", i), 32'(ff[i]), 32'(m_ff[i]));
        check($sformatf("first_fail_valid%0d", i), 32'(ffv[i]), 32'(m_ffv[i]));
    endtask

    // One clock cycle: drive while clk low, update model at the edge, sample 1 time unit later.
    task automatic cycle(input bit s, input bit v, input bit a, input bit b, input bit o);
        @(negedge clk);
        start = s; in_valid = v; in_a = a; in_b = b; in_out = o;
        @(posedge clk);
        model_step(0, s, v, a, b, o);
        model_step(1, s, v, a, b, o);
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic good_vec(input bit a, input bit b);
        cycle(1'b0, 1'b1, a, b, golden(OP0, a, b));
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(0);
        check_all(1);
        check("rst_async_cnt0", 32'(cnt[0]), 0);
        @(negedge clk);
        start = 0; in_valid = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        bit a, b, v, s;
        m_op[0] = OP0; m_nv[0] = NV0;
        m_op[1] = OP1; m_nv[1] = NV1;
        model_reset();
        rst_n = 1'b0;
        start = 0; in_valid = 0; in_a = 0; in_b = 0; in_out = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all(0);
        check_all(1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1, 1, 0, 1);   // valid in IDLE is dropped

        // Correct XOR truth table.
        cycle(1, 0, 0, 0, 0);
        good_vec(0, 0); good_vec(0, 1); good_vec(1, 0); good_vec(1, 1);
        check("xor_good_done", 32'(dn[0]), 1);
        check("xor_good_pass", 32'(ps[0]), 1);
        check("xor_good_ready", 32'(rdy[0]), 0);
        repeat (3) cycle(0, 1, 1, 1, 1);   // valid held in DONE is dropped
        check("done_hold_cnt", 32'(cnt[0]), 4);

        // Last vector wrong: 11 -> 1.
        cycle(1, 1, 0, 0, 1);
        good_vec(0, 0); good_vec(0, 1); good_vec(1, 0);
        cycle(0, 1, 1, 1, 1);
        check("bad_last_err", 32'(err[0]), 1);
        check("bad_last_ff", 32'(ff[0]), 7);
        check("bad_last_ffv", 32'(ffv[0]), 1);
        check("bad_last_pass", 32'(ps[0]), 0);

        // Gaps in valid plus start pulses during the run.
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 60 && !m_done[0]; k++) begin
            a = 1'($urandom); b = 1'($urandom);
            v = 1'($urandom); s = 1'($urandom);
            cycle(s, v, a, b, golden(OP0, a, b));
        end
        check("gaps_done", 32'(dn[0]), 1);
        check("gaps_cnt", 32'(cnt[0]), 4);

        // Reset mid-run, then a fresh good run.
        cycle(1, 0, 0, 0, 0);
        good_vec(1, 1); good_vec(0, 1);
        async_reset();
        cycle(0, 1, 1, 1, 0);
        check("post_rst_idle_cnt", 32'(cnt[0]), 0);
        cycle(1, 0, 0, 0, 0);
        good_vec(1, 0); good_vec(0, 0); good_vec(1, 1); good_vec(0, 1);
        check("post_rst_pass", 32'(ps[0]), 1);

        // 255-sample run with every sample wrong on the NAND instance.
        async_reset();
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 255; k++) begin
            a = 1'($urandom); b = 1'($urandom);
            cycle(0, 1, a, b, ~golden(OP1, a, b));
        end
        check("sat_err", 32'(err[1]), 255);
        check("sat_cnt", 32'(cnt[1]), 255);
        check("sat_done", 32'(dn[1]), 1);
        check("sat_pass", 32'(ps[1]), 0);

        // Random traffic with occasional starts and errors.
        for (int k = 0; k < 1500; k++) begin
            a = 1'($urandom); b = 1'($urandom);
            v = $urandom_range(0, 9) < 7;
            s = $urandom_range(0, 19) == 0;
            cycle(s, v, a, b, golden(OP0, a, b) ^ ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
